// File: rtl/spi_slave_burst_controller.sv
// rtl/spi_slave_burst_controller.sv - SPI slave protocol controller: cmd/addr/dummy/data phases, wrap bursts
// Optional reg1 and wrap bursts: define SPI_SLAVE_WRAP_EN.
module spi_slave_burst_controller #(
    parameter int CMD_WIDTH     = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DUMMY_DEFAULT = 32
) (
    input  logic                  sclk,
    input  logic                  sys_rst,
    input  logic                  cs,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    output logic [7:0]            rx_counter,
    output logic                  rx_counter_upd,
    output logic [7:0]            tx_counter,
    output logic                  tx_counter_upd,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_done,
    output logic                  ctrl_rd_wr,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_addr_valid,
    output logic [DATA_WIDTH-1:0] ctrl_data_rx,
    output logic                  ctrl_data_rx_valid,
    input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
    input  logic                  ctrl_data_tx_valid,
    output logic                  ctrl_data_tx_ready,
    output logic                  underrun
);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DUMMY, S_DATA_RX, S_DATA_TX, S_REG_RX, S_REG_TX, S_IGNORE
    } state_t;

    localparam logic [7:0]            CMD_CNT   = 8'(CMD_WIDTH - 1);
    localparam logic [7:0]            ADDR_CNT  = 8'(ADDR_WIDTH - 1);
    localparam logic [7:0]            DATA_CNT  = 8'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                  state, state_nxt;
    logic [7:0]              cmd;
    logic [7:0]              reg0;
    logic [15:0]             reg1;
    logic                    reg_sel;
    logic [ADDR_WIDTH-1:0]   base;
    logic [15:0]             offset;
    logic                    beat_seen;
    logic                    tx_trigger, reg_rd, beat, wrap_hit;

    assign cmd = 8'(rx_data);

    always_ff @(posedge sclk) begin
        if (sys_rst) state <= S_CMD;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs) begin
            state_nxt = S_CMD;
        end else if (rx_data_valid) begin
            case (state)
                S_CMD: begin
                    case (cmd)
                        8'h02, 8'h0B: state_nxt = S_ADDR;
                        8'h01, 8'h11: state_nxt = S_REG_RX;
                        8'h05, 8'h15: state_nxt = S_REG_TX;
                        default:      state_nxt = S_IGNORE;
                    endcase
                end
                S_ADDR:   state_nxt = !ctrl_rd_wr ? S_DATA_RX :
                                      (reg0 == 8'd0) ? S_DATA_TX : S_DUMMY;
                S_DUMMY:  state_nxt = S_DATA_TX;
                S_REG_RX: state_nxt = S_IGNORE;
                default:  state_nxt = state;
            endcase
        end
    end

    // rx_counter describes the word that follows, so it tracks the next state
    always_comb begin
        case (state_nxt)
            S_CMD:   rx_counter = CMD_CNT;
            S_ADDR:  rx_counter = ADDR_CNT;
            S_DUMMY: rx_counter = reg0 - 8'd1;
            default: rx_counter = DATA_CNT;
        endcase
        rx_counter_upd     = !cs && rx_data_valid &&
                             (state == S_CMD || state == S_ADDR || state == S_DUMMY || state == S_REG_RX);
        ctrl_data_rx       = rx_data;
        ctrl_data_rx_valid = !cs && rx_data_valid && (state == S_DATA_RX);
        tx_trigger         = !cs && ((rx_data_valid && state == S_ADDR && ctrl_rd_wr && reg0 == 8'd0) ||
                                     (rx_data_valid && state == S_DUMMY) ||
                                     (tx_done && state == S_DATA_TX));
        ctrl_data_tx_ready = tx_trigger;
        reg_rd             = !cs && rx_data_valid && (state == S_CMD) && (cmd == 8'h05 || cmd == 8'h15);
        beat               = ctrl_data_rx_valid || (tx_trigger && ctrl_data_tx_valid);
    end

`ifdef SPI_SLAVE_WRAP_EN
    always_ff @(posedge sclk) begin
        if (sys_rst)
            reg1 <= 16'd0;
        else if (!cs && rx_data_valid && state == S_REG_RX && reg_sel)
            reg1 <= 16'(rx_data);
    end
    assign wrap_hit = (reg1 != 16'd0) && (offset == reg1 - 16'd1);
`else
    assign reg1     = 16'd0;
    assign wrap_hit = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (sys_rst)
            reg0 <= 8'(DUMMY_DEFAULT);
        else if (!cs && rx_data_valid && state == S_REG_RX && !reg_sel)
            reg0 <= 8'(rx_data);
    end

    always_ff @(posedge sclk) begin
        if (sys_rst || cs) begin
            ctrl_rd_wr      <= 1'b0;
            ctrl_addr       <= '0;
            ctrl_addr_valid <= 1'b0;
            base            <= '0;
            offset          <= 16'd0;
            beat_seen       <= 1'b0;
            reg_sel         <= 1'b0;
            tx_data         <= '0;
            tx_data_valid   <= 1'b0;
            tx_counter      <= 8'd0;
            tx_counter_upd  <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            ctrl_addr_valid <= 1'b0;
            tx_data_valid   <= 1'b0;
            tx_counter_upd  <= 1'b0;
            if (state == S_CMD && rx_data_valid) begin
                reg_sel    <= cmd[4];
                ctrl_rd_wr <= (cmd == 8'h0B);
            end
            if (state == S_ADDR && rx_data_valid) begin
                ctrl_addr       <= ADDR_WIDTH'(rx_data);
                base            <= ADDR_WIDTH'(rx_data);
                offset          <= 16'd0;
                ctrl_addr_valid <= 1'b1;
            end
            if (reg_rd || tx_trigger) begin
                tx_data_valid  <= 1'b1;
                tx_counter_upd <= 1'b1;
                tx_counter     <= DATA_CNT;
                if (reg_rd)
                    tx_data <= cmd[4] ? DATA_WIDTH'(reg1) : DATA_WIDTH'(reg0);
                else if (ctrl_data_tx_valid)
                    tx_data <= ctrl_data_tx;
                else begin
                    tx_data  <= '0;
                    underrun <= 1'b1;
                end
            end
            // The first data beat uses the captured address; later beats step it
            if (beat) beat_seen <= 1'b1;
            if (beat && beat_seen) begin
                ctrl_addr_valid <= 1'b1;
                if (wrap_hit) begin
                    ctrl_addr <= base;
                    offset    <= 16'd0;
                end else begin
                    ctrl_addr <= ctrl_addr + ADDR_STEP;
                    offset    <= offset + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_burst_controller.sv
// tb/tb_spi_slave_burst_controller.sv - scoreboard bench for spi_slave_burst_controller
module tb_spi_slave_burst_controller;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          sclk = 1'b0;
    logic          sys_rst, cs, rx_data_valid, tx_done;
    logic [DW-1:0] rx_data;
    logic [7:0]    rx_counter, tx_counter;
    logic          rx_counter_upd, tx_counter_upd, tx_data_valid;
    logic [DW-1:0] tx_data, ctrl_data_rx, ctrl_data_tx;
    logic          ctrl_rd_wr, ctrl_addr_valid, ctrl_data_rx_valid;
    logic          ctrl_data_tx_valid, ctrl_data_tx_ready, underrun;
    logic [AW-1:0] ctrl_addr;

    always #5 sclk = ~sclk;

    spi_slave_burst_controller dut (
        .sclk(sclk), .sys_rst(sys_rst), .cs(cs),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
        .tx_counter(tx_counter), .tx_counter_upd(tx_counter_upd),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_done(tx_done),
        .ctrl_rd_wr(ctrl_rd_wr), .ctrl_addr(ctrl_addr), .ctrl_addr_valid(ctrl_addr_valid),
        .ctrl_data_rx(ctrl_data_rx), .ctrl_data_rx_valid(ctrl_data_rx_valid),
        .ctrl_data_tx(ctrl_data_tx), .ctrl_data_tx_valid(ctrl_data_tx_valid),
        .ctrl_data_tx_ready(ctrl_data_tx_ready), .underrun(underrun)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] exp_addr[$];
    logic [63:0] exp_rx[$];
    logic [63:0] exp_tx[$];
    logic [DW-1:0] fifo_q[$];
    logic        pop_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: unexpected strobe with value %0h, nothing expected", name, act);
    endtask

    // Monitor: compares every DUT strobe against the head of its queue
    always @(negedge sclk) begin
        if (!sys_rst) begin
            if (ctrl_addr_valid) begin
                if (exp_addr.size() == 0) unexpected("ctrl_addr", {31'd0, ctrl_rd_wr, ctrl_addr});
                else chk("ctrl_addr", {31'd0, ctrl_rd_wr, ctrl_addr}, exp_addr.pop_front());
            end
            if (ctrl_data_rx_valid) begin
                if (exp_rx.size() == 0) unexpected("ctrl_data_rx", 64'(ctrl_data_rx));
                else chk("ctrl_data_rx", 64'(ctrl_data_rx), exp_rx.pop_front());
            end
            if (tx_data_valid) begin
                if (exp_tx.size() == 0) unexpected("tx_data", 64'(tx_data));
                else begin
                    chk("tx_data", 64'(tx_data), exp_tx.pop_front());
                    chk("tx_counter", 64'({tx_counter_upd, tx_counter}), 64'h11F);
                end
            end
        end
        pop_now = ctrl_data_tx_ready && ctrl_data_tx_valid;
    end

    // Bus-side read FIFO model
    always @(posedge sclk) begin
        #1;
        if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        ctrl_data_tx_valid = (fifo_q.size() != 0);
        ctrl_data_tx       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [DW-1:0] w);
        rx_data = w;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] w);
        pulse(w);
        idle(3);
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic frame_start;
        cs = 1'b0;
        idle(2);
    endtask

    task automatic frame_end;
        cs = 1'b1;
        idle(2);
    endtask

    initial begin
        sys_rst = 1'b1; cs = 1'b1; rx_data = '0; rx_data_valid = 1'b0; tx_done = 1'b0;
        ctrl_data_tx = '0; ctrl_data_tx_valid = 1'b0;
        idle(2);
        chk("rst_rx_counter", 64'(rx_counter), 64'd7);
        chk("rst_strobes", 64'({tx_data_valid, tx_counter_upd, ctrl_addr_valid, ctrl_data_rx_valid,
                                ctrl_data_tx_ready, underrun, ctrl_rd_wr}), 64'd0);
        chk("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);
        chk("rst_tx_counter", 64'(tx_counter), 64'd0);
        sys_rst = 1'b0;
        idle(2);

        // reg0 readback gives the reset dummy count
        frame_start();
        exp_tx.push_back(64'd32);
        send(32'h05);
        frame_end();

        // WRITE 3 words at 0x100
        frame_start();
        rx_data = 32'h02; rx_data_valid = 1'b1; #1;
        chk("cmd_rx_counter_upd", 64'(rx_counter_upd), 64'd1);
        chk("cmd_next_rx_counter", 64'(rx_counter), 64'd31);
        tick(); rx_data_valid = 1'b0; idle(3);
        exp_addr.push_back(64'h0_0000_0100);
        exp_addr.push_back(64'h0_0000_0104);
        exp_addr.push_back(64'h0_0000_0108);
        exp_rx.push_back(64'hAAAA_0001);
        exp_rx.push_back(64'hBBBB_0002);
        exp_rx.push_back(64'hCCCC_0003);
        send(32'h100);
        send(32'hAAAA_0001);
        send(32'hBBBB_0002);
        send(32'hCCCC_0003);
        chk("write_rd_wr", 64'(ctrl_rd_wr), 64'd0);
        frame_end();

        // reg1 = 2, then read it back
        frame_start();
        send(32'h11);
        send(32'h2);
        frame_end();
        frame_start();
`ifdef SPI_SLAVE_WRAP_EN
        exp_tx.push_back(64'd2);
`else
        exp_tx.push_back(64'd0);
`endif
        send(32'h15);
        frame_end();

        // READ 4 words at 0x40 with 32 dummy cycles
        fifo_q.push_back(32'hD000_0000);
        fifo_q.push_back(32'hD111_1111);
        fifo_q.push_back(32'hD222_2222);
        fifo_q.push_back(32'hD333_3333);
        idle(2);
        frame_start();
        exp_addr.push_back(64'h1_0000_0040);
`ifdef SPI_SLAVE_WRAP_EN
        exp_addr.push_back(64'h1_0000_0044);
        exp_addr.push_back(64'h1_0000_0040);
        exp_addr.push_back(64'h1_0000_0044);
`else
        exp_addr.push_back(64'h1_0000_0044);
        exp_addr.push_back(64'h1_0000_0048);
        exp_addr.push_back(64'h1_0000_004C);
`endif
        exp_tx.push_back(64'hD000_0000);
        exp_tx.push_back(64'hD111_1111);
        exp_tx.push_back(64'hD222_2222);
        exp_tx.push_back(64'hD333_3333);
        send(32'h0B);
        send(32'h40);
        chk("dummy_rx_counter", 64'(rx_counter), 64'd31);
        send(32'h0);
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            idle(3);
        end
        chk("read_rd_wr", 64'(ctrl_rd_wr), 64'd1);
        chk("fifo_drained", 64'(fifo_q.size()), 64'd0);
        frame_end();

        // reg0 = 0: DUMMY skipped, data one cycle after the address word
        frame_start();
        send(32'h01);
        send(32'h0);
        frame_end();
        fifo_q.push_back(32'hE0E0_E0E0);
        idle(2);
        frame_start();
        exp_addr.push_back(64'h1_0000_0080);
        exp_tx.push_back(64'hE0E0_E0E0);
        send(32'h0B);
        chk("lat_before", 64'(tx_data_valid), 64'd0);
        pulse(32'h80);
        chk("lat_valid", 64'(tx_data_valid), 64'd1);
        chk("no_dummy_rx_counter", 64'(rx_counter), 64'd31);
        tick();
        chk("lat_pulse_end", 64'(tx_data_valid), 64'd0);
        idle(2);
        frame_end();

        // Underrun on the 2nd pop, cleared by cs
        fifo_q.push_back(32'hF0F0_0001);
        idle(2);
        frame_start();
        exp_addr.push_back(64'h1_0000_0200);
        exp_tx.push_back(64'hF0F0_0001);
        exp_tx.push_back(64'h0);
        send(32'h0B);
        send(32'h200);
        chk("underrun_clear_before", 64'(underrun), 64'd0);
        pulse_done();
        chk("underrun_set", 64'(underrun), 64'd1);
        idle(3);
        cs = 1'b1;
        tick();
        chk("underrun_cs_clear", 64'(underrun), 64'd0);
        chk("cs_state_cmd", 64'(rx_counter), 64'd7);
        idle(2);

        // Unknown command, then 64 bits and a stray tx_done
        frame_start();
        send(32'hFF);
        send(32'hDEAD_BEEF);
        send(32'h1234_5678);
        tx_done = 1'b1; #1;
        chk("ignore_ready", 64'(ctrl_data_tx_ready), 64'd0);
        tick(); tx_done = 1'b0; idle(2);
        chk("ignore_rd_wr", 64'(ctrl_rd_wr), 64'd0);
        frame_end();

        // cs abort coinciding with the address word
        frame_start();
        send(32'h02);
        rx_data = 32'h300; rx_data_valid = 1'b1; cs = 1'b1; #1;
        chk("abort_no_upd", 64'(rx_counter_upd), 64'd0);
        tick();
        rx_data_valid = 1'b0;
        chk("abort_no_addr", 64'(ctrl_addr_valid), 64'd0);
        idle(2);
        frame_start();
        exp_addr.push_back(64'h0_0000_0300);
        exp_rx.push_back(64'h6666_7777);
        send(32'h02);
        send(32'h300);
        send(32'h6666_7777);
        frame_end();

        idle(5);
        chk("addr_queue_empty", 64'(exp_addr.size()), 64'd0);
        chk("rx_queue_empty", 64'(exp_rx.size()), 64'd0);
        chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
